// File: rtl/product_accumulator.sv
// product_accumulator: sums up to N_TERMS unsigned 8-bit products per result, valid/ready on both sides.
// Define PRODUCT_ACCUM_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       acc_cnt,
    output logic             acc_valid,
    input  logic             acc_ready
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum_clip;
    logic [3:0]       cnt_q, cnt_d;
    logic [ACC_W:0]   sum;
    logic             accept;
    assign accept = prod_valid && state_q == ACCUM;
    assign sum    = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_in};
`ifdef PRODUCT_ACCUM_SAT_EN
    // once clamped, any further add carries out again, so the sum stays at max
    assign sum_clip = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign sum_clip = sum[ACC_W-1:0];
`endif
    always_comb begin
        state_d = state_q;
        acc_d   = accept ? sum_clip : acc_q;
        cnt_d   = accept ? cnt_q + 4'd1 : cnt_q;
        if (state_q == HOLD) begin
            state_d = acc_ready ? ACCUM : HOLD;
            acc_d   = acc_ready ? '0 : acc_q;
            cnt_d   = acc_ready ? '0 : cnt_q;
        end else if ((accept && cnt_d == 4'(N_TERMS)) || (flush && cnt_d != 4'd0)) begin
            state_d = HOLD;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
    assign prod_ready = state_q == ACCUM;
    assign acc_valid  = state_q == HOLD;
    assign acc_out    = acc_q;
    assign acc_cnt    = cnt_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench; a cycle model pushes expected results, DUT handshakes pop them.
module tb_product_accumulator;
    localparam int N = 4;
    localparam int W = 10;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] prod_in = '0, b_prod_in = '0;
    logic prod_valid = 1'b0, flush = 1'b0, acc_ready = 1'b0;
    logic b_prod_valid = 1'b0;
    logic prod_ready, acc_valid, b_prod_ready, b_acc_valid;
    logic [W-1:0] acc_out;
    logic [7:0] b_acc_out;
    logic [3:0] acc_cnt, b_acc_cnt;
    int checks = 0, errors = 0;
    bit m_hold = 1'b0;
    int m_acc = 0, m_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(N), .ACC_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .flush(flush), .acc_out(acc_out), .acc_cnt(acc_cnt),
        .acc_valid(acc_valid), .acc_ready(acc_ready));

    product_accumulator #(.N_TERMS(4), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .prod_in(b_prod_in), .prod_valid(b_prod_valid),
        .prod_ready(b_prod_ready), .flush(1'b0), .acc_out(b_acc_out), .acc_cnt(b_acc_cnt),
        .acc_valid(b_acc_valid), .acc_ready(1'b0));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int add_model(input int a, input int p, input int w);
        int mx = (1 << w) - 1;
`ifdef PRODUCT_ACCUM_SAT_EN
        return (a + p > mx) ? mx : a + p;
`else
        return (a + p) & mx;
`endif
    endfunction

    // one clock: drive at negedge, check outputs against the model, then advance the model
    task automatic step(input bit pv, input int p, input bit fl, input bit ar);
        @(negedge clk);
        prod_valid = pv; prod_in = 8'(p); flush = fl; acc_ready = ar;
        #1;
        chk("prod_ready", int'(prod_ready), int'(!m_hold));
        chk("acc_valid", int'(acc_valid), int'(m_hold));
        if (m_hold && exp_q.size() > 0) begin
            chk("acc_out", int'(acc_out), exp_q[0] >> 4);
            chk("acc_cnt", int'(acc_cnt), exp_q[0] & 15);
            if (ar) void'(exp_q.pop_front());
        end
        if (m_hold) begin
            if (ar) begin m_hold = 1'b0; m_acc = 0; m_cnt = 0; end
        end else begin
            if (pv) begin m_acc = add_model(m_acc, p, W); m_cnt++; end
            if ((pv && m_cnt == N) || (fl && m_cnt > 0)) begin
                m_hold = 1'b1;
                exp_q.push_back((m_acc << 4) | m_cnt);
            end
        end
    endtask

    initial begin
        int bv[4] = '{200, 100, 0, 0};
        int sat_exp;
        bit seen;
        #1;
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_acc_cnt", int'(acc_cnt), 0);
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_prod_ready", int'(prod_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        // four back-to-back products, consumer always ready
        step(1, 10, 0, 1); step(1, 30, 0, 1); step(1, 225, 0, 1); step(1, 225, 0, 1);
        chk("sb_490_pending", exp_q.size(), 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        // hold with acc_ready low while upstream keeps offering
        step(1, 50, 0, 0); step(1, 60, 0, 0); step(1, 70, 0, 0); step(1, 80, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 99, 0, 0);
        step(1, 99, 0, 1); step(1, 99, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 1);
        // flush with a same-cycle product, then a lone flush on empty
        step(1, 5, 0, 0); step(1, 7, 0, 0); step(1, 3, 1, 0); step(0, 0, 0, 1);
        step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        // reset in the middle of accumulation
        step(1, 10, 0, 0); step(1, 20, 0, 0);
        @(negedge clk); prod_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid_rst_acc_out", int'(acc_out), 0);
        chk("mid_rst_acc_cnt", int'(acc_cnt), 0);
        chk("mid_rst_prod_ready", int'(prod_ready), 1);
        chk("mid_rst_acc_valid", int'(acc_valid), 0);
        m_hold = 1'b0; m_acc = 0; m_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 0);
        chk("sb_empty", exp_q.size(), 0);
        // narrow accumulator overflow
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); b_prod_valid = 1'b1; b_prod_in = 8'(bv[i]);
        end
        @(negedge clk); b_prod_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            #1 seen = b_acc_valid;
            if (!seen) @(negedge clk);
        end
`ifdef PRODUCT_ACCUM_SAT_EN
        sat_exp = 255;
`else
        sat_exp = 44;
`endif
        chk("ovf_valid", int'(seen), 1);
        chk("ovf_acc_out", int'(b_acc_out), sat_exp);
        chk("ovf_acc_cnt", int'(b_acc_cnt), 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
